// File: rtl/generic_bus_mem_responder.sv
// Memory-side responder for generic_bus_if: word-organised SRAM with a fixed access latency.
// Each read or byte-masked write completes with a single-cycle busy=0 pulse.
module generic_bus_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 4,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter logic [31:0] OOR_RDATA   = 32'hBAD1_BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_count;
    logic [3:0]  w_count_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_is_read;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_req;
    logic        w_enter_resp;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic [3:0]  w_acc_be;
    logic        w_acc_read;
    logic [29:0] w_word;
    logic        w_in_range;
    logic [AW-1:0] w_idx;
    logic [31:0] w_old;
    logic [31:0] w_merged;
    logic        w_mem_we;

    assign w_req = ren | wen;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_count_next = r_count;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (LATENCY == 1) begin
                        w_next       = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next       = WAIT;
                        w_count_next = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                // Dropping the request aborts even on the cycle that would have completed it.
                if (!w_req) begin
                    w_next       = IDLE;
                    w_count_next = '0;
                end else if (r_count == 4'd1) begin
                    w_next       = RESP;
                    w_count_next = '0;
                    w_enter_resp = 1'b1;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the sample edge itself, so live inputs are used.
    assign w_acc_addr  = (r_state == IDLE) ? addr    : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? wdata   : r_wdata;
    assign w_acc_be    = (r_state == IDLE) ? byte_en : r_be;
    assign w_acc_read  = (r_state == IDLE) ? ren     : r_is_read;

    assign w_word     = w_acc_addr[31:2] - ADDR_BASE[31:2];
    assign w_in_range = ({2'b00, w_word} < 32'(DEPTH_WORDS));
    assign w_idx      = w_word[AW-1:0];
    assign w_old      = r_mem[w_idx];

    always_comb begin
        w_merged = w_old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_acc_be[i]) begin
                w_merged[8*i +: 8] = w_acc_wdata[8*i +: 8];
            end
        end
    end

    assign w_mem_we = w_enter_resp & ~w_acc_read & w_in_range & (|w_acc_be);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_is_read <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_addr    <= addr;
                r_wdata   <= wdata;
                r_be      <= byte_en;
                r_is_read <= ren;
            end
            if (w_enter_resp && w_acc_read) begin
                r_rdata <= w_in_range ? w_old : OOR_RDATA;
            end
        end
    end

    // Array is not reset; contents are undefined until written or preloaded.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign busy  = (r_state != RESP);
    assign rdata = r_rdata;

endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// Directed bench for generic_bus_mem_responder (DEPTH_WORDS=1024, LATENCY=4).
// Memory is preloaded with 32'hA500_0000 | index at time 0.
module tb_generic_bus_mem_responder;

    logic        CLK;
    logic        nRST;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        busy;

    int n_vec;
    int n_err;

    generic_bus_mem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (4),
        .ADDR_BASE  (32'h0000_0000),
        .OOR_RDATA  (32'hBAD1_BAD1)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .addr   (addr),
        .wdata  (wdata),
        .ren    (ren),
        .wen    (wen),
        .byte_en(byte_en),
        .rdata  (rdata),
        .busy   (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives one request, waits (bounded) for the busy=0 pulse, then lets the FSM return to IDLE.
    task automatic issue(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, output int lat);
        ren = r; wen = w; addr = a; wdata = d; byte_en = be;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (busy === 1'b0) begin
                lat = k;
                break;
            end
        end
        ren = 1'b0; wen = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_vec++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
        nRST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            n_vec++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL idle_busy[%0d]: got %b want 1", k, busy); end
        end
        n_vec++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL idle_rdata: got %h want 00000000", rdata); end
    endtask

    task automatic test_read_latency;
        logic [4:0] obs;
        obs = '1;
        ren = 1'b1; wen = 1'b0; addr = 32'h10; wdata = '0; byte_en = '0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK); #1;
            obs[k-1] = busy;
            if (k == 4) ren = 1'b0;
        end
        n_vec++;
        if (obs !== 5'b10111) begin n_err++; $display("FAIL read_busy_pattern: got %b want 10111", obs); end
        n_vec++;
        if (rdata !== 32'hA500_0004) begin n_err++; $display("FAIL read_0x10: got %h want A5000004", rdata); end
    endtask

    task automatic test_back_to_back;
        int t_w;
        int t_r;
        int lat;
        t_w = -1; t_r = -1;
        ren = 1'b0; wen = 1'b1; addr = 32'h20; wdata = 32'hDEAD_BEEF; byte_en = 4'b0101;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (busy === 1'b0) begin t_w = k; break; end
        end
        ren = 1'b1; wen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (busy === 1'b0) begin t_r = k; break; end
        end
        ren = 1'b0;
        n_vec++;
        if (t_w != 4) begin n_err++; $display("FAIL b2b_write_latency: got %0d want 4", t_w); end
        n_vec++;
        if (t_r != 5) begin n_err++; $display("FAIL b2b_interval: got %0d want 5", t_r); end
        n_vec++;
        if (rdata !== 32'hA5AD_00EF) begin n_err++; $display("FAIL b2b_merged_read: got %h want A5AD00EF", rdata); end
        @(posedge CLK); #1;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_after: got %b want 1", busy); end
        // An all-lanes-disabled write completes but leaves the word alone.
        issue(1'b0, 1'b1, 32'h20, 32'h1111_1111, 4'b0000, lat);
        n_vec++;
        if (lat != 4) begin n_err++; $display("FAIL be0_write_latency: got %0d want 4", lat); end
        n_vec++;
        if (rdata !== 32'hA5AD_00EF) begin n_err++; $display("FAIL be0_rdata_hold: got %h want A5AD00EF", rdata); end
        issue(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, lat);
        n_vec++;
        if (rdata !== 32'hA5AD_00EF) begin n_err++; $display("FAIL be0_read_back: got %h want A5AD00EF", rdata); end
    endtask

    task automatic test_abort;
        int pulses;
        int lat;
        pulses = 0;
        ren = 1'b1; wen = 1'b0; addr = 32'h30; byte_en = '0;
        repeat (2) begin @(posedge CLK); #1; if (busy === 1'b0) pulses++; end
        ren = 1'b0;
        repeat (8) begin @(posedge CLK); #1; if (busy === 1'b0) pulses++; end
        n_vec++;
        if (pulses != 0) begin n_err++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
        n_vec++;
        if (rdata !== 32'hA5AD_00EF) begin n_err++; $display("FAIL abort_rdata: got %h want A5AD00EF", rdata); end
        issue(1'b0, 1'b1, 32'h30, 32'hDEAD_BEEF, 4'b0101, lat);
        n_vec++;
        if (lat != 4) begin n_err++; $display("FAIL abort_write_latency: got %0d want 4", lat); end
        issue(1'b1, 1'b0, 32'h30, 32'h0, 4'b0000, lat);
        n_vec++;
        if (rdata !== 32'hA5AD_00EF) begin n_err++; $display("FAIL abort_read_0x30: got %h want A5AD00EF", rdata); end
    endtask

    task automatic test_out_of_range;
        int lat;
        issue(1'b1, 1'b0, 32'h0000_F000, 32'h0, 4'b0000, lat);
        n_vec++;
        if (lat != 4) begin n_err++; $display("FAIL oor_read_latency: got %0d want 4", lat); end
        n_vec++;
        if (rdata !== 32'hBAD1_BAD1) begin n_err++; $display("FAIL oor_read: got %h want BAD1BAD1", rdata); end
        issue(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'b0000, lat);
        n_vec++;
        if (rdata !== 32'hA500_0000) begin n_err++; $display("FAIL read_0x0: got %h want A5000000", rdata); end
        issue(1'b0, 1'b1, 32'h0000_F000, 32'h1234_5678, 4'b1111, lat);
        n_vec++;
        if (lat != 4) begin n_err++; $display("FAIL oor_write_latency: got %0d want 4", lat); end
        n_vec++;
        if (rdata !== 32'hA500_0000) begin n_err++; $display("FAIL oor_write_rdata_hold: got %h want A5000000", rdata); end
        issue(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'b0000, lat);
        n_vec++;
        if (rdata !== 32'hA500_0000) begin n_err++; $display("FAIL oor_write_no_alias: got %h want A5000000", rdata); end
    endtask

    task automatic test_both_and_reset;
        int lat;
        int t_p;
        issue(1'b1, 1'b1, 32'h40, 32'h0000_0000, 4'b1111, lat);
        n_vec++;
        if (rdata !== 32'hA500_0010) begin n_err++; $display("FAIL both_read: got %h want A5000010", rdata); end
        issue(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, lat);
        n_vec++;
        if (rdata !== 32'hA500_0010) begin n_err++; $display("FAIL both_word_kept: got %h want A5000010", rdata); end

        // Reset while in RESP: busy must rise without waiting for a clock edge.
        t_p = -1;
        ren = 1'b1; wen = 1'b0; addr = 32'h48;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (busy === 1'b0) begin t_p = k; break; end
        end
        n_vec++;
        if (t_p != 4) begin n_err++; $display("FAIL pre_reset_read_latency: got %0d want 4", t_p); end
        nRST = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL resp_reset_busy: got %b want 1", busy); end
        n_vec++;
        if (rdata !== 32'h0) begin n_err++; $display("FAIL resp_reset_rdata: got %h want 00000000", rdata); end
        ren = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Reset mid-WAIT on a write: the write must be lost.
        ren = 1'b0; wen = 1'b1; addr = 32'h44; wdata = 32'hFFFF_FFFF; byte_en = 4'b1111;
        repeat (2) @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL wait_reset_busy: got %b want 1", busy); end
        wen = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        issue(1'b1, 1'b0, 32'h44, 32'h0, 4'b0000, lat);
        n_vec++;
        if (lat != 4) begin n_err++; $display("FAIL post_reset_latency: got %0d want 4", lat); end
        n_vec++;
        if (rdata !== 32'hA500_0011) begin n_err++; $display("FAIL lost_write_0x44: got %h want A5000011", rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        nRST = 1'b0;
        ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; byte_en = '0;
        for (int i = 0; i < 1024; i++) begin
            dut.r_mem[i] = 32'hA500_0000 | 32'(i);
        end
        test_reset;
        test_read_latency;
        @(posedge CLK); #1;
        test_back_to_back;
        test_abort;
        test_out_of_range;
        test_both_and_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
